// File: rtl/display_scan_bcd_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : display_scan_bcd_pkg
//  Description : Shared constants and types for the scanned BCD display.
//                Active-low 7-segment patterns (bit order a..g, seg[0] = a),
//                anode-off constant, digit-index type, converter state type
//                and the segment decode helper.
//  Revision    : 1.0  initial release
// ============================================================================
package display_scan_bcd_pkg;

    // Segment patterns, abcdefg, active-low
    localparam logic [0:6] SEG_0     = 7'b0000001;
    localparam logic [0:6] SEG_1     = 7'b1001111;
    localparam logic [0:6] SEG_2     = 7'b0010010;
    localparam logic [0:6] SEG_3     = 7'b0000110;
    localparam logic [0:6] SEG_4     = 7'b1001100;
    localparam logic [0:6] SEG_5     = 7'b0100100;
    localparam logic [0:6] SEG_6     = 7'b0100000;
    localparam logic [0:6] SEG_7     = 7'b0001111;
    localparam logic [0:6] SEG_8     = 7'b0000000;
    localparam logic [0:6] SEG_9     = 7'b0000100;
    localparam logic [0:6] SEG_BLANK = 7'b1111111;

    // All four anodes released
    localparam logic [3:0] AN_OFF = 4'b1111;

    // Index of the digit currently being scanned (0 = units)
    typedef logic [1:0] dig_idx_t;

    // Sequential converter state
    typedef enum logic [0:0] {
        CONV_IDLE  = 1'b0,
        CONV_SHIFT = 1'b1
    } conv_state_t;

    // BCD nibble to segment pattern; the unreachable codes 10..15 show blank
    function automatic logic [0:6] seg_decode(input logic [3:0] d);
        logic [0:6] s;
        case (d)
            4'd0:    s = SEG_0;
            4'd1:    s = SEG_1;
            4'd2:    s = SEG_2;
            4'd3:    s = SEG_3;
            4'd4:    s = SEG_4;
            4'd5:    s = SEG_5;
            4'd6:    s = SEG_6;
            4'd7:    s = SEG_7;
            4'd8:    s = SEG_8;
            4'd9:    s = SEG_9;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

endpackage
`default_nettype wire

// File: rtl/display_scan_bcd_if.sv
`default_nettype none
// ============================================================================
//  Module      : display_scan_bcd_if
//  Description : Load/display bundle of the scanned BCD display.
//                value  - binary value to show (WIDTH bits)
//                load   - capture strobe, honoured only while busy is low
//                busy   - conversion in progress
//                seg    - segments a..g as seg[0]..seg[6], active-low
//                an     - digit anodes, active-low one-hot, an[0] = units
//                master : the producer of value/load (consumes the display)
//                slave  : the display block
//  Revision    : 1.0  initial release
// ============================================================================
interface display_scan_bcd_if #(
    parameter int WIDTH = 5
);
    logic [WIDTH-1:0] value;
    logic             load;
    logic             busy;
    logic [0:6]       seg;
    logic [3:0]       an;

    modport master (
        output value,
        output load,
        input  busy,
        input  seg,
        input  an
    );

    modport slave (
        input  value,
        input  load,
        output busy,
        output seg,
        output an
    );
endinterface
`default_nettype wire

// File: rtl/display_scan_bcd_bin2bcd.sv
`default_nettype none
// ============================================================================
//  Module      : bin2bcd_seq
//  Description : Sequential double-dabble converter, one shift per clock.
//                A start while idle captures bin; WIDTH shift cycles follow.
//                done is high during the last shift cycle, so the edge that
//                ends it is the commit edge; bcd carries the final result
//                while done is high.
//  Ports       : clk   in   system clock
//                rst   in   asynchronous active-low reset
//                start in   capture request (ignored while busy)
//                bin   in   binary value, WIDTH bits
//                busy  out  conversion in progress
//                done  out  final shift cycle, bcd is valid
//                bcd   out  NDIG packed BCD nibbles, nibble 0 = units
//  Revision    : 1.0  initial release
// ============================================================================
module bin2bcd_seq
    import display_scan_bcd_pkg::*;
#(
    parameter int WIDTH = 5,
    parameter int NDIG  = 4
) (
    input  wire logic                clk,
    input  wire logic                rst,
    input  wire logic                start,
    input  wire logic [WIDTH-1:0]    bin,
    output logic                     busy,
    output logic                     done,
    output logic [4*NDIG-1:0]        bcd
);

    localparam int SRW = 4*NDIG + WIDTH;
    localparam int CW  = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    conv_state_t      state_q, state_d;
    logic [SRW-1:0]   sr_q,    sr_d;
    logic [CW-1:0]    cnt_q,   cnt_d;

    logic [SRW-1:0]   w_adj;
    logic [SRW-1:0]   w_shift;
    logic             w_last;

    // Add 3 to every BCD nibble >= 5 ahead of the shift so that the
    // doubling carries correctly into the next decade.
    always_comb begin
        w_adj = sr_q;
        for (int k = 0; k < NDIG; k++) begin
            if (sr_q[WIDTH + 4*k +: 4] >= 4'd5) begin
                w_adj[WIDTH + 4*k +: 4] = sr_q[WIDTH + 4*k +: 4] + 4'd3;
            end
        end
    end

    assign w_shift = w_adj << 1;
    assign w_last  = (state_q == CONV_SHIFT) && (cnt_q == CW'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= CONV_IDLE;
            sr_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        case (state_q)
            CONV_IDLE: begin
                if (start) begin
                    sr_d    = SRW'(bin);
                    cnt_d   = '0;
                    state_d = CONV_SHIFT;
                end
            end
            CONV_SHIFT: begin
                sr_d  = w_shift;
                cnt_d = cnt_q + 1'b1;
                if (w_last) begin
                    state_d = CONV_IDLE;
                end
            end
            default: state_d = CONV_IDLE;
        endcase
    end

    assign busy = (state_q == CONV_SHIFT);
    assign done = w_last;
    assign bcd  = w_shift[SRW-1:WIDTH];

endmodule
`default_nettype wire

// File: rtl/display_scan_bcd.sv
`default_nettype none
// ============================================================================
//  Module      : display_scan_bcd
//  Description : Converts a loaded binary value to BCD sequentially and
//                scans the digits onto a common-anode 4-digit 7-segment
//                display. The scan runs continuously; the stored digits are
//                replaced in one step when a conversion completes.
//  Ports       : clk   in   system clock
//                rst   in   asynchronous active-low reset
//                bus   slave modport: value/load in, busy/seg/an out
//  Parameters  : WIDTH    binary input width (1..13)
//                NDIG     number of digits (4)
//                DIV      clocks per digit slot (>= 2)
//                BLANK_LZ 1 = blank leading zeros above the units digit
//  Revision    : 1.0  initial release
// ============================================================================
module display_scan_bcd
    import display_scan_bcd_pkg::*;
#(
    parameter int WIDTH    = 5,
    parameter int NDIG     = 4,
    parameter int DIV      = 50000,
    parameter int BLANK_LZ = 1
) (
    input  wire logic         clk,
    input  wire logic         rst,
    display_scan_bcd_if.slave bus
);

    localparam int PW = $clog2(DIV);

    logic [PW-1:0]       presc_q,  presc_d;
    dig_idx_t            idx_q,    idx_d;
    logic [4*NDIG-1:0]   digits_q, digits_d;
    logic [0:6]          seg_q,    seg_d;
    logic [NDIG-1:0]     an_q,     an_d;

    logic                w_busy;
    logic                w_done;
    logic [4*NDIG-1:0]   w_bcd;
    logic [NDIG-1:0]     w_blank;
    logic                w_zero_above;
    logic [3:0]          w_digit;
    logic                w_wrap;

    bin2bcd_seq #(
        .WIDTH (WIDTH),
        .NDIG  (NDIG)
    ) u_conv (
        .clk   (clk),
        .rst   (rst),
        .start (bus.load),
        .bin   (bus.value),
        .busy  (w_busy),
        .done  (w_done),
        .bcd   (w_bcd)
    );

    // Leading-zero blanking: walk down from the top digit, a digit is blank
    // while it and everything above it is zero. The units digit always shows.
    always_comb begin
        w_blank      = '0;
        w_zero_above = 1'b1;
        for (int k = NDIG - 1; k >= 1; k--) begin
            w_zero_above = w_zero_above && (digits_q[4*k +: 4] == 4'd0);
            w_blank[k]   = (BLANK_LZ != 0) && w_zero_above;
        end
    end

    assign w_wrap  = (presc_q == PW'(DIV - 1));
    assign w_digit = digits_q[4*int'(idx_q) +: 4];

    always_comb begin
        presc_d  = w_wrap ? '0 : presc_q + 1'b1;
        idx_d    = idx_q;
        if (w_wrap) begin
            idx_d = (idx_q == dig_idx_t'(NDIG - 1)) ? '0 : idx_q + 1'b1;
        end
        // All digits are replaced together on the commit edge
        digits_d = w_done ? w_bcd : digits_q;
        seg_d    = w_blank[idx_q] ? SEG_BLANK : seg_decode(w_digit);
        an_d     = ~(NDIG'(1) << idx_q);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc_q  <= '0;
            idx_q    <= '0;
            digits_q <= '0;
            seg_q    <= SEG_BLANK;
            an_q     <= AN_OFF;
        end else begin
            presc_q  <= presc_d;
            idx_q    <= idx_d;
            digits_q <= digits_d;
            seg_q    <= seg_d;
            an_q     <= an_d;
        end
    end

    assign bus.busy = w_busy;
    assign bus.seg  = seg_q;
    assign bus.an   = an_q;

endmodule
`default_nettype wire

// File: tb/tb_display_scan_bcd.sv
`default_nettype none
// ============================================================================
//  Module      : tb_display_scan_bcd
//  Description : Self-checking bench. Two instances share the stimulus, one
//                with leading-zero blanking and one without. A behavioural
//                model (decimal arithmetic on the loaded number, an edge
//                counter for the scan) is compared on every cycle, and a
//                table of values with their expected per-slot patterns plus
//                hand-written sequences cover the multi-cycle corners.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_display_scan_bcd;

    localparam int WIDTH = 5;
    localparam int NDIG  = 4;
    localparam int DIV   = 4;

    localparam logic [6:0] P0 = 7'b0000001;
    localparam logic [6:0] P1 = 7'b1001111;
    localparam logic [6:0] P2 = 7'b0010010;
    localparam logic [6:0] P3 = 7'b0000110;
    localparam logic [6:0] P5 = 7'b0100100;
    localparam logic [6:0] P6 = 7'b0100000;
    localparam logic [6:0] P7 = 7'b0001111;
    localparam logic [6:0] P9 = 7'b0000100;
    localparam logic [6:0] PB = 7'b1111111;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic [WIDTH-1:0] value = '0;
    logic load = 1'b0;

    always #5 clk = ~clk;

    display_scan_bcd_if #(.WIDTH(WIDTH)) bus1 ();
    display_scan_bcd_if #(.WIDTH(WIDTH)) bus0 ();

    assign bus1.value = value;
    assign bus1.load  = load;
    assign bus0.value = value;
    assign bus0.load  = load;

    display_scan_bcd #(.WIDTH(WIDTH), .NDIG(NDIG), .DIV(DIV), .BLANK_LZ(1)) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1.slave)
    );

    display_scan_bcd #(.WIDTH(WIDTH), .NDIG(NDIG), .DIV(DIV), .BLANK_LZ(0)) u_dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0.slave)
    );

    int checks = 0;
    int errors = 0;

    // ---------------- behavioural model ----------------
    int         m_edges, m_left, m_disp, m_pend, m_slot;
    logic       m_busy;
    logic [3:0] m_an;
    logic [6:0] m_seg1, m_seg0;

    function automatic logic [6:0] ref_seg(input int val, input int k, input bit blz);
        int p;
        int d;
        p = 1;
        for (int i = 0; i < k; i++) p = p * 10;
        d = (val / p) % 10;
        if (blz && k > 0 && val < p) return PB;
        case (d)
            0: return 7'b0000001;
            1: return 7'b1001111;
            2: return 7'b0010010;
            3: return 7'b0000110;
            4: return 7'b1001100;
            5: return 7'b0100100;
            6: return 7'b0100000;
            7: return 7'b0001111;
            8: return 7'b0000000;
            default: return 7'b0000100;
        endcase
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_edges = 0; m_left = 0; m_disp = 0; m_pend = 0;
            m_busy = 1'b0; m_an = 4'hF; m_seg1 = PB; m_seg0 = PB;
        end else begin
            // outputs reflect the scan slot and number held before this edge
            m_slot = (m_edges / DIV) % NDIG;
            m_an   = ~(4'b0001 << m_slot);
            m_seg1 = ref_seg(m_disp, m_slot, 1'b1);
            m_seg0 = ref_seg(m_disp, m_slot, 1'b0);
            m_edges = m_edges + 1;
            if (m_left > 0) begin
                m_left = m_left - 1;
                if (m_left == 0) m_disp = m_pend;
            end else if (load) begin
                m_pend = int'(value);
                m_left = WIDTH;
            end
            m_busy = (m_left > 0);
        end
    end

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        chk("busy_lz1", 32'(bus1.busy), 32'(m_busy));
        chk("busy_lz0", 32'(bus0.busy), 32'(m_busy));
        chk("an_lz1",   32'(bus1.an),   32'(m_an));
        chk("an_lz0",   32'(bus0.an),   32'(m_an));
        chk("seg_lz1",  32'(bus1.seg),  32'(m_seg1));
        chk("seg_lz0",  32'(bus0.seg),  32'(m_seg0));
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (bus1.busy && n < 30) begin
            n++;
            tick();
        end
        chk("busy_timeout", 32'(bus1.busy), 32'd0);
    endtask

    task automatic load_val(input int v);
        value = WIDTH'(v);
        load  = 1'b1;
        tick();
        load  = 1'b0;
    endtask

    // Records the pattern seen in each slot over a full scan round
    task automatic capture(output logic [3:0][6:0] c1, output logic [3:0][6:0] c0);
        c1 = '1;
        c0 = '1;
        tick();
        repeat (NDIG * DIV) begin
            tick();
            for (int j = 0; j < NDIG; j++) begin
                if (bus1.an == ~(4'b0001 << j)) c1[j] = bus1.seg;
                if (bus0.an == ~(4'b0001 << j)) c0[j] = bus0.seg;
            end
        end
    endtask

    typedef struct {
        int               val;
        logic [3:0][6:0]  s1;   // slot3..slot0, blanking on
        logic [3:0][6:0]  s0;   // slot3..slot0, blanking off
    } vec_t;

    vec_t tbl [6];

    initial begin
        logic [3:0][6:0] c1, c0;
        int n;

        tbl[0] = '{27, {PB, PB, P2, P7}, {P0, P0, P2, P7}};
        tbl[1] = '{31, {PB, PB, P3, P1}, {P0, P0, P3, P1}};
        tbl[2] = '{0,  {PB, PB, PB, P0}, {P0, P0, P0, P0}};
        tbl[3] = '{9,  {PB, PB, PB, P9}, {P0, P0, P0, P9}};
        tbl[4] = '{10, {PB, PB, P1, P0}, {P0, P0, P1, P0}};
        tbl[5] = '{16, {PB, PB, P1, P6}, {P0, P0, P1, P6}};

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_seg",  32'(bus1.seg),  32'h7F);
        chk("rst_an",   32'(bus1.an),   32'hF);
        chk("rst_busy", 32'(bus1.busy), 32'h0);
        rst = 1'b1;
        tick();
        chk("first_an",  32'(bus1.an),  32'(4'b1110));
        chk("first_seg", 32'(bus1.seg), 32'(P0));

        // Conversion length
        load_val(27);
        n = 0;
        while (bus1.busy && n < 20) begin
            n++;
            tick();
        end
        chk("busy_len", 32'(n), 32'd5);

        // Table of values and their per-slot display
        foreach (tbl[i]) begin
            wait_idle();
            load_val(tbl[i].val);
            wait_idle();
            capture(c1, c0);
            for (int j = 0; j < NDIG; j++) begin
                chk($sformatf("tbl%0d_lz1_slot%0d", tbl[i].val, j), 32'(c1[j]), 32'(tbl[i].s1[j]));
                chk($sformatf("tbl%0d_lz0_slot%0d", tbl[i].val, j), 32'(c0[j]), 32'(tbl[i].s0[j]));
            end
        end

        // Loads while busy and on the busy-falling edge are ignored
        wait_idle();
        load_val(27);            // busy sample 1
        tick();                  // 2
        value = 9; load = 1'b1;
        tick();                  // 3
        load = 1'b0;
        tick();                  // 4
        tick();                  // 5, last busy cycle
        value = 9; load = 1'b1;  // lands on the busy-falling edge
        tick();
        load = 1'b0;
        chk("busy_after_fall_load", 32'(bus1.busy), 32'd0);
        tick();
        chk("no_restart", 32'(bus1.busy), 32'd0);
        capture(c1, c0);
        chk("ign_slot0", 32'(c1[0]), 32'(P7));
        chk("ign_slot1", 32'(c1[1]), 32'(P2));

        // Reset during the third busy cycle
        load_val(5);
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("midrst_busy", 32'(bus1.busy), 32'd0);
        chk("midrst_an",   32'(bus1.an),   32'hF);
        chk("midrst_seg",  32'(bus1.seg),  32'h7F);
        tick();
        rst = 1'b1;
        tick();
        chk("post_rst_an",  32'(bus1.an),  32'(4'b1110));
        chk("post_rst_seg", 32'(bus1.seg), 32'(P0));
        repeat (10) tick();
        capture(c1, c0);
        chk("post_rst_slot0", 32'(c1[0]), 32'(P0));
        chk("post_rst_slot1", 32'(c1[1]), 32'(PB));

        // Random loads against the model
        repeat (400) begin
            value = WIDTH'($urandom_range(31));
            load  = ($urandom_range(3) == 0);
            tick();
        end
        load = 1'b0;
        repeat (20) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
